// File: rtl/lorenz_sample_tx.sv
// rtl/lorenz_sample_tx.sv - decimated x/y/z snapshot serialiser onto a byte valid/ready stream
// Optional trailing XOR checksum byte: define LORENZ_TX_CHECKSUM_EN.
module lorenz_sample_tx #(
  parameter int N       = 32,
  parameter int DECIM_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               enable,
  input  logic [DECIM_W-1:0] decim,
  input  logic [N-1:0]       x,
  input  logic [N-1:0]       y,
  input  logic [N-1:0]       z,
  input  logic               clr_ovr,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [15:0]        frame_count,
  output logic               overrun
);

  localparam int NB = N / 8;
`ifdef LORENZ_TX_CHECKSUM_EN
  localparam int FL = 2 + 3 * NB;
`else
  localparam int FL = 1 + 3 * NB;
`endif
  localparam int BW = $clog2(FL);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state;
  logic [DECIM_W-1:0] dcnt;
  logic [DECIM_W-1:0] dlim;
  logic [N-1:0]       sx, sy, sz;
  logic [BW-1:0]      bidx;
  logic [BW-1:0]      nidx;
  logic               tick, xfer, last, accept;
  logic [8*FL-1:0]    frame_w;
  logic [7:0]         fbytes [FL];

  function automatic logic [8*FL-1:0] frame_of(input logic [N-1:0] a, input logic [N-1:0] b,
                                               input logic [N-1:0] c);
    logic [8*FL-1:0] f;
`ifdef LORENZ_TX_CHECKSUM_EN
    logic [7:0] cs;
    cs = '0;
    for (int i = 0; i < NB; i++) cs = cs ^ a[8*i +: 8] ^ b[8*i +: 8] ^ c[8*i +: 8];
    f = {8'hA5, a, b, c, cs};
`else
    f = {8'hA5, a, b, c};
`endif
    return f;
  endfunction

  // decim == 0 behaves as 1, so the compare limit is never negative
  assign dlim   = (decim == '0) ? '0 : decim - 1'b1;
  assign tick   = run && enable && (dcnt == dlim);
  assign xfer   = tx_valid && tx_ready;
  assign last   = xfer && (bidx == BW'(FL - 1));
  assign accept = tick && ((state == IDLE) || last);
  assign nidx   = bidx + 1'b1;

  assign frame_w = frame_of(sx, sy, sz);

  always_comb begin
    for (int i = 0; i < FL; i++) fbytes[i] = frame_w[8*(FL-1-i) +: 8];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      dcnt        <= '0;
      sx          <= '0;
      sy          <= '0;
      sz          <= '0;
      bidx        <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      frame_count <= '0;
      overrun     <= 1'b0;
    end else begin
      if (!(run && enable) || tick) dcnt <= '0;
      else                          dcnt <= dcnt + 1'b1;

      if (accept) begin
        sx <= x;
        sy <= y;
        sz <= z;
      end

      if (tick && !accept) overrun <= 1'b1;
      else if (clr_ovr)    overrun <= 1'b0;

      if (last) frame_count <= frame_count + 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            state    <= SEND;
            bidx     <= '0;
            tx_valid <= 1'b1;
            tx_data  <= 8'hA5;
          end
        end
        SEND: begin
          if (xfer) begin
            if (last) begin
              bidx <= '0;
              if (accept) begin
                tx_data <= 8'hA5;
              end else begin
                state    <= IDLE;
                tx_valid <= 1'b0;
                tx_data  <= 8'h00;
              end
            end else begin
              // next byte comes from the current shadow; a capture only happens on the last byte
              bidx    <= nidx;
              tx_data <= fbytes[nidx];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
